// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and baud helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_STOP_BITS = 1;
  localparam int unsigned UART_BIT_CNT_W = 3;
  localparam logic        UART_LINE_IDLE = 1'b1;

  function automatic int unsigned baud_period(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM with a valid/ready byte output,
// frame-error pulse, sticky overrun flag and an LED mirror of the last byte.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_in,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] status_leds
);

  localparam int unsigned BAUD_PERIOD = baud_period(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W       = $clog2(BAUD_PERIOD);
  localparam int unsigned HALF        = BAUD_PERIOD / 2;

  localparam logic [CNT_W-1:0]          HALF_TC = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]          BIT_TC  = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [UART_BIT_CNT_W-1:0] LAST_BIT = UART_BIT_CNT_W'(UART_DATA_BITS - 1);

  logic rx_s;
  logic rx_prev_q;

  uart_rx_state_t              state_q,   state_d;
  logic [CNT_W-1:0]            cnt_q,     cnt_d;
  logic [UART_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0]   shift_q,   shift_d;
  logic                        deliver_c;
  logic                        stop_err_c;

  logic [7:0]            rx_data_q;
  logic                  rx_valid_q;
  logic                  frame_err_q;
  logic                  overrun_q;
  logic [DATA_WIDTH-1:0] leds_q;

  sync_2ff #(
    .RESET_VAL (UART_LINE_IDLE)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (rx_in),
    .q_o   (rx_s)
  );

  // FSM and receive datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev_q <= UART_LINE_IDLE;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    deliver_c  = 1'b0;
    stop_err_c = 1'b0;
    case (state_q)
      // Only a true 1->0 edge starts a frame, so a held-low line cannot retrigger.
      IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_TC) begin
          cnt_d            = '0;
          shift_d[bit_cnt_q] = rx_s;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + UART_BIT_CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_TC) begin
          cnt_d      = '0;
          state_d    = IDLE;
          deliver_c  = rx_s;
          stop_err_c = !rx_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output byte, handshake and error flags; a pending unaccepted byte is never overwritten
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      leds_q      <= '0;
    end else begin
      frame_err_q <= stop_err_c;
      if (deliver_c && (!rx_valid_q || rx_ready)) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
        leds_q     <= shift_q[DATA_WIDTH-1:0];
      end else if (rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (deliver_c && rx_valid_q && !rx_ready) begin
        overrun_q <= 1'b1;
      end else if (err_clear) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign status_leds = leds_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus randomized
// frames with baud mismatch, checked against an expected-byte scoreboard.
module tb_uart_receiver;

  localparam int unsigned CLK_FREQ  = 100_000_000;
  localparam int unsigned BAUD_RATE = 6_250_000;
  localparam int unsigned DW        = 4;
  localparam int unsigned BIT_T     = 160;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          rx_in     = 1'b1;
  logic          rx_ready  = 1'b0;
  logic          err_clear = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic [DW-1:0] status_leds;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int ferr_seen = 0;
  int xfer_seen = 0;
  logic ferr_prev = 1'b0;
  logic [7:0] exp_q[$];

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .err_clear   (err_clear),
    .status_leds (status_leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_t);
    rx_in = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      #(bit_t);
    end
    rx_in = stop_bit;
    #(bit_t);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every accepted byte must be the oldest expected one
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      if (frame_err) begin
        ferr_seen++;
        check("frame_err_width", 32'(ferr_prev), 32'd0);
      end
      if (rx_valid && rx_ready) begin
        xfer_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h expected none (t=%0t)", rx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e));
          check("status_leds", 32'(status_leds), 32'(e[DW-1:0]));
        end
      end
    end
    ferr_prev = frame_err;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    int ferr_base;
    int xfer_base;
    int bt;
    logic [7:0] d;
    logic done;

    // Reset values
    wait_cycles(3);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_leds", 32'(status_leds), 32'd0);
    reset = 1'b1;
    wait_cycles(5);

    // 1: single byte, consumer ready, exact latency
    rx_ready = 1'b1;
    exp_q.push_back(8'hA5);
    @(posedge clk);
    #2;
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, BIT_T);
      begin
        n = 0;
        while (!rx_valid && n < 400) begin
          @(negedge clk);
          n++;
        end
        check("t1_latency", 32'(cyc - t0), 32'd155);
        check("t1_data", 32'(rx_data), 32'hA5);
        check("t1_leds", 32'(status_leds), 32'h5);
        @(negedge clk);
        check("t1_valid_one_cycle", 32'(rx_valid), 32'd0);
      end
    join
    wait_cycles(10);
    check("t1_no_ferr", 32'(ferr_seen), 32'd0);
    check("t1_no_overrun", 32'(overrun), 32'd0);

    // 2: two back-to-back frames while not ready -> second dropped, overrun
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_T);
    send_frame(8'hC3, 1'b1, BIT_T);
    wait_cycles(20);
    check("t2_valid", 32'(rx_valid), 32'd1);
    check("t2_data", 32'(rx_data), 32'h3C);
    check("t2_leds", 32'(status_leds), 32'hC);
    check("t2_overrun", 32'(overrun), 32'd1);
    @(posedge clk);
    #1;
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    @(negedge clk);
    check("t2_overrun_cleared", 32'(overrun), 32'd0);
    check("t2_valid_held", 32'(rx_valid), 32'd1);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    wait_cycles(3);
    check("t2_valid_after_accept", 32'(rx_valid), 32'd0);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: stop bit low, then line held low (break)
    ferr_base = ferr_seen;
    xfer_base = xfer_seen;
    send_frame(8'h55, 1'b0, BIT_T);
    #(20 * BIT_T);
    check("t3_ferr_count", 32'(ferr_seen - ferr_base), 32'd1);
    check("t3_no_valid", 32'(rx_valid), 32'd0);
    check("t3_data_kept", 32'(rx_data), 32'h3C);
    check("t3_leds_kept", 32'(status_leds), 32'hC);
    rx_in = 1'b1;
    wait_cycles(40);
    check("t3_no_retrigger", 32'(ferr_seen - ferr_base), 32'd1);
    check("t3_no_xfer", 32'(xfer_seen - xfer_base), 32'd0);

    // 4: short low glitch on the idle line (under half a bit)
    ferr_base = ferr_seen;
    @(posedge clk);
    #2;
    rx_in = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rx_in = 1'b1;
    wait_cycles(2 * 10 * 16);
    check("t4_no_valid", 32'(rx_valid), 32'd0);
    check("t4_no_ferr", 32'(ferr_seen - ferr_base), 32'd0);
    check("t4_no_xfer", 32'(xfer_seen - xfer_base), 32'd0);

    // 5: reset in the middle of bit 4 of 0xFF, then a clean 0x81
    fork
      send_frame(8'hFF, 1'b1, BIT_T);
      begin
        #(5 * BIT_T + BIT_T / 2);
        reset = 1'b0;
        #33;
        check("t5_rst_data", 32'(rx_data), 32'd0);
        check("t5_rst_leds", 32'(status_leds), 32'd0);
        reset = 1'b1;
      end
    join
    wait_cycles(20);
    check("t5_no_partial", 32'(rx_valid), 32'd0);
    xfer_base = xfer_seen;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, BIT_T);
    wait_cycles(20);
    check("t5_one_xfer", 32'(xfer_seen - xfer_base), 32'd1);
    check("t5_leds", 32'(status_leds), 32'h1);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: random bytes, +/-3% bit time, random consumer stalls
    ferr_base = ferr_seen;
    xfer_base = xfer_seen;
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 256; f++) begin
          d  = 8'($urandom);
          bt = int'($urandom_range(155, 165));
          exp_q.push_back(d);
          send_frame(d, 1'b1, bt);
          #($urandom_range(0, 60));
        end
        wait_cycles(40);
        done = 1'b1;
      end
      begin
        int pend;
        pend = 0;
        while (!done) begin
          @(posedge clk);
          #1;
          pend = rx_valid ? pend + 1 : 0;
          rx_ready = (pend > 6) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        rx_ready = 1'b1;
      end
    join
    wait_cycles(5);
    check("t6_xfer_count", 32'(xfer_seen - xfer_base), 32'd256);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t6_no_ferr", 32'(ferr_seen - ferr_base), 32'd0);
    check("t6_no_overrun", 32'(overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
